// File: rtl/main_mem_refill.sv
// Main-memory model for cache refill: read requests return a 4-word line,
// write requests commit one word, both after a fixed accept-to-response latency.
module main_mem_refill #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  line_valid,
  output logic [LINE_WIDTH-1:0] line_data,
  output logic                  wr_done
);

  localparam int IDXW  = $clog2(MEM_DEPTH);
  localparam int CNTW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int WORDS = 4;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} stateT;

  stateT                 state, nextState;
  logic [CNTW-1:0]       count;
  logic [IDXW-1:0]       reqIdx, capIdx, opIdx;
  logic [DATA_WIDTH-1:0] capData, opData;
  logic                  capWrite;
  logic                  acceptRd, acceptWr, finishRd, finishWr;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  unusedAddrBits;

  assign reqIdx         = addr[IDXW+1:2];
  assign unusedAddrBits = ^{addr[1:0], addr[ADDR_WIDTH-1:IDXW+2]};

  // With LATENCY=1 the operation completes on the accept edge, so the live
  // request is used directly instead of the captured copy.
  assign opIdx  = (state == IDLE) ? reqIdx : capIdx;
  assign opData = (state == IDLE) ? wdata  : capData;

  assign busy       = (state != IDLE);
  assign line_valid = (state == DONE) && !capWrite;
  assign wr_done    = (state == DONE) && capWrite;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    acceptRd  = 1'b0;
    acceptWr  = 1'b0;
    finishRd  = 1'b0;
    finishWr  = 1'b0;
    case (state)
      IDLE: begin
        // Writes win over a simultaneous read; the dropped read is re-issued upstream.
        if (wr_req) begin
          acceptWr = 1'b1;
          if (LATENCY == 1) begin
            nextState = DONE;
            finishWr  = 1'b1;
          end else begin
            nextState = WR_WAIT;
          end
        end else if (rd_req) begin
          acceptRd = 1'b1;
          if (LATENCY == 1) begin
            nextState = DONE;
            finishRd  = 1'b1;
          end else begin
            nextState = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (count <= CNTW'(1)) begin
          nextState = DONE;
          finishRd  = 1'b1;
        end
      end
      WR_WAIT: begin
        if (count <= CNTW'(1)) begin
          nextState = DONE;
          finishWr  = 1'b1;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      capIdx    <= '0;
      capData   <= '0;
      capWrite  <= 1'b0;
      line_data <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (acceptRd || acceptWr) begin
        count    <= CNTW'(LATENCY - 1);
        capIdx   <= reqIdx;
        capData  <= wdata;
        capWrite <= acceptWr;
      end else if (state == RD_WAIT || state == WR_WAIT) begin
        count <= count - CNTW'(1);
      end
      if (finishWr) mem[opIdx] <= opData;
      // Line base is the word index with its low two bits cleared.
      if (finishRd) begin
        for (int k = 0; k < WORDS; k++)
          line_data[k*DATA_WIDTH +: DATA_WIDTH] <= mem[{opIdx[IDXW-1:2], 2'(k)}];
      end
    end
  end

endmodule

// File: tb/tb_main_mem_refill.sv
// Directed bench for main_mem_refill: reads, writes, collisions, busy
// lockout and mid-request reset, with hand-computed expected lines.
module tb_main_mem_refill;

  logic         clk;
  logic         reset;
  logic         rd_req;
  logic         wr_req;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic         busy;
  logic         line_valid;
  logic [127:0] line_data;
  logic         wr_done;

  int vectorCount;
  int miscompareCount;
  int lvCycle, wdCycle, lvCount, wdCount, busyCount, bothCount;

  main_mem_refill dut (
    .clk        (clk),
    .reset      (reset),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .line_valid (line_valid),
    .line_data  (line_data),
    .wr_done    (wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d);
    rd_req = rd;
    wr_req = wr;
    addr   = a;
    wdata  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vectorCount++;
    assert (observed === expected)
    else begin
      miscompareCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Issue one request on the next edge, then watch a fixed 8-cycle window.
  task automatic runOp(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    lvCycle = -1; wdCycle = -1;
    lvCount = 0; wdCount = 0; busyCount = 0; bothCount = 0;
    applyStimulus(rd, wr, a, d);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      if (busy) busyCount++;
      if (line_valid) begin lvCount++; if (lvCycle < 0) lvCycle = c; end
      if (wr_done)    begin wdCount++; if (wdCycle < 0) wdCycle = c; end
      if (line_valid && wr_done) bothCount++;
      tick();
    end
  endtask

  initial begin
    vectorCount     = 0;
    miscompareCount = 0;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    #12;
    checkOutput("reset busy",       128'(busy),       128'd0);
    checkOutput("reset line_valid", 128'(line_valid), 128'd0);
    checkOutput("reset wr_done",    128'(wr_done),    128'd0);
    checkOutput("reset line_data",  line_data,        128'h0);
    tick();
    reset = 1'b1;

    // Read of a cleared line: pulse in 4th busy cycle, busy for 4 cycles
    runOp(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    checkOutput("rd0 lv cycle",  128'(lvCycle),   128'd4);
    checkOutput("rd0 lv count",  128'(lvCount),   128'd1);
    checkOutput("rd0 wd count",  128'(wdCount),   128'd0);
    checkOutput("rd0 busy cyc",  128'(busyCount), 128'd4);
    checkOutput("rd0 line",      line_data,       128'h0);

    // Single write then line read
    runOp(1'b0, 1'b1, 32'h0000_0024, 32'hDEAD_BEEF);
    checkOutput("wr24 wd cycle", 128'(wdCycle),   128'd4);
    checkOutput("wr24 wd count", 128'(wdCount),   128'd1);
    checkOutput("wr24 lv count", 128'(lvCount),   128'd0);
    checkOutput("wr24 busy cyc", 128'(busyCount), 128'd4);
    checkOutput("wr keeps line", line_data,       128'h0);
    runOp(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    checkOutput("rd20 lv count", 128'(lvCount),   128'd1);
    checkOutput("rd20 line",     line_data,
                128'h00000000_00000000_DEADBEEF_00000000);

    // Fill a whole line, read with an unaligned address inside it
    runOp(1'b0, 1'b1, 32'h0000_0040, 32'h11);
    runOp(1'b0, 1'b1, 32'h0000_0044, 32'h22);
    runOp(1'b0, 1'b1, 32'h0000_0048, 32'h33);
    runOp(1'b0, 1'b1, 32'h0000_004C, 32'h44);
    runOp(1'b1, 1'b0, 32'h0000_004B, 32'h0);
    checkOutput("rd4B lv cycle", 128'(lvCycle), 128'd4);
    checkOutput("rd4B line",     line_data,
                128'h00000044_00000033_00000022_00000011);

    // Simultaneous read and write: write wins
    runOp(1'b1, 1'b1, 32'h0000_0060, 32'hCAFE_F00D);
    checkOutput("both wd count", 128'(wdCount), 128'd1);
    checkOutput("both lv count", 128'(lvCount), 128'd0);
    checkOutput("both line hold", line_data,
                128'h00000044_00000033_00000022_00000011);
    runOp(1'b1, 1'b0, 32'h0000_0060, 32'h0);
    checkOutput("reissue line",  line_data, 128'h00000000_00000000_00000000_CAFEF00D);

    // Address wrap: upper bits beyond the depth are ignored
    runOp(1'b1, 1'b0, 32'hFFFF_F024, 32'h0);
    checkOutput("wrap line",     line_data,
                128'h00000000_00000000_DEADBEEF_00000000);

    // Requests while busy are ignored
    lvCount = 0; wdCount = 0; bothCount = 0;
    applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h0000_0024, 32'h0000_0055);
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      if (line_valid) lvCount++;
      if (wr_done)    wdCount++;
      tick();
    end
    checkOutput("busy lv count", 128'(lvCount), 128'd1);
    checkOutput("busy wd count", 128'(wdCount), 128'd0);
    checkOutput("busy line",     line_data,
                128'h00000000_00000000_DEADBEEF_00000000);
    runOp(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    checkOutput("busy no commit", line_data,
                128'h00000000_00000000_DEADBEEF_00000000);
    checkOutput("never both",    128'(bothCount), 128'd0);

    // Reset during WR_WAIT aborts the write
    applyStimulus(1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;
    #2;
    checkOutput("abort busy",    128'(busy), 128'd0);
    checkOutput("abort line",    line_data,  128'h0);
    tick();
    reset = 1'b1;
    wdCount = 0;
    for (int c = 0; c < 6; c++) begin
      if (wr_done) wdCount++;
      tick();
    end
    checkOutput("abort wd count", 128'(wdCount), 128'd0);
    runOp(1'b1, 1'b0, 32'h0000_0080, 32'h0);
    checkOutput("abort rd cycle", 128'(lvCycle), 128'd4);
    checkOutput("abort rd line",  line_data,     128'h0);
    runOp(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    checkOutput("mem cleared",    line_data,     128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule

// File: doc/main_mem_refill.md
MAIN_MEM_REFILL -- requirements
Module: main_mem_refill

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
  DATA_WIDTH, 32, word width.
  LINE_WIDTH, 128, refill line width (4 words).
  ADDR_WIDTH, 32, byte address width.
  MEM_DEPTH, 1024, backing store depth in words (power of 2, multiple of 4).
  LATENCY, 4, accept-to-response delay in cycles (>=1).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be as follows, one per line: name, direction, width, meaning.
  clk  in  1  clock, rising edge.
  reset  in  1  asynchronous, active-low reset.
  rd_req  in  1  line refill request (cache miss).
  wr_req  in  1  word write-through request.
  addr  in  ADDR_WIDTH  byte address of the request.
  wdata  in  DATA_WIDTH  write word.
  busy  out  1  request in progress; new requests are ignored.
  line_valid  out  1  one-cycle pulse; line_data holds the refill line.
  line_data  out  LINE_WIDTH  refill line, word k at bits [32k+31:32k].
  wr_done  out  1  one-cycle pulse; the write has been committed.

Function
REQ-004 Word index SHALL be addr[log2(MEM_DEPTH)+1:2]; addr[1:0] ignored; upper bits beyond depth ignored (wrap).
REQ-005 Line base SHALL be word index with bits [1:0] forced to 00; line word k = mem[base+k], k=0..3.
REQ-006 FSM states SHALL be IDLE, RD_WAIT, WR_WAIT, DONE; busy = (state != IDLE).
REQ-007 In IDLE, a rising edge with wr_req=1 SHALL capture addr/wdata, load counter with LATENCY-1, and go to WR_WAIT.
REQ-008 In IDLE, a rising edge with rd_req=1 and wr_req=0 SHALL capture addr, load counter with LATENCY-1, and go to RD_WAIT.
REQ-009 When rd_req and wr_req are both high in IDLE, the write SHALL be accepted and the read dropped; the requester re-issues it.
REQ-010 In RD_WAIT/WR_WAIT, the counter SHALL decrement each edge; on the edge where the counter equals 0, the state SHALL go to DONE.
REQ-011 On the RD_WAIT->DONE edge, line_data SHALL register the line at the captured address, and line_valid SHALL be 1 for the DONE cycle only.
REQ-012 On the WR_WAIT->DONE edge, mem[captured index] SHALL take the captured wdata, and wr_done SHALL be 1 for the DONE cycle only.
REQ-013 DONE SHALL return to IDLE on the next edge unconditionally; with LATENCY=L and acceptance at edge E0, the pulse is in the cycle after edge E0+L-1, and busy is 1 for L cycles after E0.
REQ-014 rd_req/wr_req/addr/wdata changes while busy=1 SHALL have no effect; no queuing.
REQ-015 line_data SHALL hold its value until the next read completion; it is not cleared by writes.
REQ-016 A read after a completed write to the same line SHALL return the written word.
REQ-017 line_valid and wr_done SHALL never be high in the same cycle.

Reset
REQ-018 reset=0 SHALL immediately force: state IDLE, counter 0, busy 0, line_valid 0, wr_done 0, line_data 0, all mem words 0.
REQ-019 A reset asserted mid-request SHALL abort the request: no pulse afterwards, and a pending write is not committed.
REQ-020 After reset deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-021 Reset, then read with addr=0x0000_0010 -> line_valid pulses once 4 cycles after the accept edge, line_data=128'h0, busy high 4 cycles.
REQ-022 Write addr=0x24 wdata=0xDEADBEEF, wait for wr_done, then read addr=0x20 -> line_data[63:32]=0xDEADBEEF, other words 0.
REQ-023 Four writes to 0x40..0x4C (0x11,0x22,0x33,0x44), then read addr=0x4B -> line_data=128'h00000044_00000033_00000022_00000011.
REQ-024 Simultaneous rd_req=wr_req=1 in IDLE -> only wr_done pulses; no line_valid; a read re-issued later returns the new data.
REQ-025 Second read issued while busy -> ignored; exactly one line_valid pulse; line_data matches the first address.
REQ-026 reset asserted during WR_WAIT, then read of the same line -> no wr_done; line data returns 0.
